moa_operand_loader: RTL and testbench

Upstream feeder for the 8-operand multi-operand adder (MOA). It accepts a serial stream of W-bit samples over a valid/ready handshake and gathers each group of eight into a frame. It presents each frame to the MOA as eight parallel, stable operands x0..x7. It also generates a frame-valid pulse and a `sum_valid` pulse delayed to line up with the MOA's registered `summ` output.

---
 rtl/moa_pkg.sv | 16 +
 rtl/moa_valid_delay.sv | 35 +++
 rtl/moa_operand_loader.sv | 131 +++++++++++++
 tb/tb_moa_operand_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/moa_pkg.sv
// Shared definitions for the 8-operand multi-operand adder and its feeders.
package moa_pkg;

   localparam int MOA_N       = 8;
   localparam int MOA_W       = 8;
   localparam int MOA_LAT_DEF = 2;

   typedef logic [MOA_W-1:0] moa_operand_t;
   typedef moa_operand_t     moa_operand_arr_t [MOA_N];

   // Sum of MOA_N operands of width w never overflows this width.
   function automatic int moa_sum_w(input int w);
      return w + $clog2(MOA_N);
   endfunction

endpackage

// File: rtl/moa_valid_delay.sv
// Free-running valid shift register of parameterised depth; DEPTH=0 is a wire.
module moa_valid_delay #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   output logic out_valid
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign out_valid = in_valid;
      end else begin : g_shift
         logic [DEPTH-1:0] sr_q;
         logic [DEPTH-1:0] sr_d;

         assign sr_d[0] = in_valid;
         for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
            assign sr_d[gi] = sr_q[gi-1];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sr_q <= '0;
            end else begin
               sr_q <= sr_d;
            end
         end

         assign out_valid = sr_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/moa_operand_loader.sv
// Gathers serial samples into 8-lane frames and presents them as stable MOA operands.
// Optional short-frame zero padding is enabled by defining MOA_LOADER_ZERO_PAD_EN.
module moa_operand_loader
   import moa_pkg::*;
#(
   parameter int W       = MOA_W,
   parameter int MOA_LAT = MOA_LAT_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_last,
   input  logic         out_stall,
   output logic [W-1:0] x0,
   output logic [W-1:0] x1,
   output logic [W-1:0] x2,
   output logic [W-1:0] x3,
   output logic [W-1:0] x4,
   output logic [W-1:0] x5,
   output logic [W-1:0] x6,
   output logic [W-1:0] x7,
   output logic         frame_valid,
   output logic         sum_valid,
   output logic [7:0]   frame_cnt
);

   logic [W-1:0] fill_q [MOA_N];
   logic [W-1:0] fill_d [MOA_N];
   logic [W-1:0] x_q    [MOA_N];
   logic [W-1:0] x_d    [MOA_N];
   logic [W-1:0] frame  [MOA_N];
   logic [2:0]   idx_q, idx_d;
   logic         pending_q, pending_d;
   logic         frame_valid_q, frame_valid_d;
   logic [7:0]   frame_cnt_q, frame_cnt_d;
   logic         accept;
   logic         last_hit;
   logic         complete;
   logic         release_frame;

   assign in_ready      = !pending_q;
   assign accept        = in_valid & in_ready;

`ifdef MOA_LOADER_ZERO_PAD_EN
   assign last_hit = in_last;
`else
   logic unused_in_last;
   assign unused_in_last = in_last;
   assign last_hit       = 1'b0;
`endif

   assign complete      = accept & ((idx_q == 3'd7) | last_hit);
   assign release_frame = pending_q & !out_stall;

   // Completed frame as it would look this cycle: collected lanes, incoming sample, zeros above.
   generate
      for (genvar gi = 0; gi < MOA_N; gi++) begin : g_frame
         assign frame[gi] = (3'(gi) < idx_q)  ? fill_q[gi] :
                            (3'(gi) == idx_q) ? in_data    : '0;
      end
   endgenerate

   always_comb begin
      fill_d        = fill_q;
      x_d           = x_q;
      idx_d         = idx_q;
      pending_d     = pending_q;
      frame_valid_d = 1'b0;
      if (release_frame) begin
         x_d           = fill_q;
         pending_d     = 1'b0;
         frame_valid_d = 1'b1;
      end else if (complete) begin
         idx_d = 3'd0;
         if (out_stall) begin
            fill_d    = frame;
            pending_d = 1'b1;
         end else begin
            x_d           = frame;
            frame_valid_d = 1'b1;
         end
      end else if (accept) begin
         fill_d[idx_q] = in_data;
         idx_d         = idx_q + 3'd1;
      end
      frame_cnt_d = frame_cnt_q + {7'd0, frame_valid_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MOA_N; i++) begin
            fill_q[i] <= '0;
            x_q[i]    <= '0;
         end
         idx_q         <= 3'd0;
         pending_q     <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_cnt_q   <= 8'd0;
      end else begin
         fill_q        <= fill_d;
         x_q           <= x_d;
         idx_q         <= idx_d;
         pending_q     <= pending_d;
         frame_valid_q <= frame_valid_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   moa_valid_delay #(
      .DEPTH (MOA_LAT)
   ) u_sum_valid_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (frame_valid_q),
      .out_valid (sum_valid)
   );

   assign x0          = x_q[0];
   assign x1          = x_q[1];
   assign x2          = x_q[2];
   assign x3          = x_q[3];
   assign x4          = x_q[4];
   assign x5          = x_q[5];
   assign x6          = x_q[6];
   assign x7          = x_q[7];
   assign frame_valid = frame_valid_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_moa_operand_loader.sv
// Scoreboard bench for moa_operand_loader: expected frames queued at drive time, checked on frame_valid/sum_valid.
module tb_moa_operand_loader;

   localparam int W   = 8;
   localparam int LAT = 2;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         in_last;
   logic         out_stall;
   logic [W-1:0] x0, x1, x2, x3, x4, x5, x6, x7;
   logic         frame_valid;
   logic         sum_valid;
   logic [7:0]   frame_cnt;

   moa_operand_loader #(.W(W), .MOA_LAT(LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_last     (in_last),
      .out_stall   (out_stall),
      .x0          (x0),
      .x1          (x1),
      .x2          (x2),
      .x3          (x3),
      .x4          (x4),
      .x5          (x5),
      .x6          (x6),
      .x7          (x7),
      .frame_valid (frame_valid),
      .sum_valid   (sum_valid),
      .frame_cnt   (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   typedef struct {
      int lane [8];
      int sum;
   } frame_t;

   frame_t exp_q [$];
   int     sum_q [$];
   int     sumcyc_q [$];
   int     model_buf [8];
   int     model_idx = 0;
   int     exp_cnt = 0;
   int     cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int dut_lane(input int i);
      case (i)
         0: return int'(x0);
         1: return int'(x1);
         2: return int'(x2);
         3: return int'(x3);
         4: return int'(x4);
         5: return int'(x5);
         6: return int'(x6);
         default: return int'(x7);
      endcase
   endfunction

   function automatic int dut_sum();
      int s = 0;
      for (int i = 0; i < 8; i++) s += dut_lane(i);
      return s;
   endfunction

   // Monitor: compare issued frames and the delayed sum strobe against the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_cnt = 0;
         exp_q.delete();
         sum_q.delete();
         sumcyc_q.delete();
      end else begin
         if (frame_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_frame", 1, 0);
            end else begin
               frame_t e;
               e = exp_q.pop_front();
               for (int i = 0; i < 8; i++) check_eq($sformatf("lane%0d", i), dut_lane(i), e.lane[i]);
               exp_cnt = exp_cnt + 1;
               check_eq("frame_cnt", int'(frame_cnt), exp_cnt % 256);
               sum_q.push_back(e.sum);
               sumcyc_q.push_back(cyc + LAT);
               $display("frame cnt=%0d x=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d", frame_cnt,
                        x0, x1, x2, x3, x4, x5, x6, x7);
            end
         end
         if (sum_valid) begin
            if (sum_q.size() == 0) begin
               check_eq("unexpected_sum_valid", 1, 0);
            end else begin
               int es, ec;
               es = sum_q.pop_front();
               ec = sumcyc_q.pop_front();
               check_eq("sum_valid_cycle", cyc, ec);
               check_eq("summ", dut_sum(), es);
            end
         end
      end
   end

   // Drives one sample and updates the reference lane model at the accepting edge.
   task automatic send(input int d, input logic l);
      int t = 0;
      bit done;
      in_valid = 1'b1;
      in_data  = W'(d);
      in_last  = l;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check_eq("ready_timeout", 0, 1);
      model_buf[model_idx] = d;
`ifdef MOA_LOADER_ZERO_PAD_EN
      done = (model_idx == 7) || l;
`else
      done = (model_idx == 7);
`endif
      if (done) begin
         frame_t e;
         e.sum = 0;
         for (int i = 0; i < 8; i++) begin
            e.lane[i] = (i <= model_idx) ? model_buf[i] : 0;
            e.sum += e.lane[i];
         end
         exp_q.push_back(e);
         model_idx = 0;
      end else begin
         model_idx++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int t;
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_stall = 1'b0;
      idle(3);
      for (int i = 0; i < 8; i++) check_eq($sformatf("rst_lane%0d", i), dut_lane(i), 0);
      check_eq("rst_frame_valid", int'(frame_valid), 0);
      check_eq("rst_sum_valid", int'(sum_valid), 0);
      check_eq("rst_frame_cnt", int'(frame_cnt), 0);
      check_eq("rst_in_ready", int'(in_ready), 1);
      rst_n = 1'b1;
      idle(2);

      // Normal frame 1..8
      for (int i = 1; i <= 8; i++) send(i, 1'b0);
      idle(4);

      // Stall while frame 9..16 completes
      for (int i = 9; i <= 15; i++) send(i, 1'b0);
      out_stall = 1'b1;
      send(16, 1'b0);
      for (int k = 0; k < 3; k++) begin
         check_eq("stall_in_ready", int'(in_ready), 0);
         check_eq("stall_frame_valid", int'(frame_valid), 0);
         check_eq("stall_x0_held", int'(x0), 1);
         check_eq("stall_x7_held", int'(x7), 8);
         idle(1);
      end
      out_stall = 1'b0;
      idle(1);
      check_eq("release_frame_valid", int'(frame_valid), 1);
      check_eq("release_in_ready", int'(in_ready), 1);
      idle(4);

      // Short frame with in_last
      send(10, 1'b0);
      send(20, 1'b0);
      send(30, 1'b1);
      idle(4);
`ifdef MOA_LOADER_ZERO_PAD_EN
      for (int i = 1; i <= 8; i++) send(i * 3, 1'b0);
`else
      for (int i = 4; i <= 8; i++) send(i * 10, 1'b0);
`endif
      idle(4);

      // Maximum operands
      for (int i = 0; i < 8; i++) send(255, 1'b0);
      idle(4);

      // Counter wrap over 256 more frames, with back-to-back random data
      for (int f = 0; f < 256; f++)
         for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 255)), 1'b0);
      idle(6);

      // Asynchronous reset in the middle of a partial frame
      for (int i = 0; i < 5; i++) send(200 + i, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) check_eq($sformatf("mid_rst_lane%0d", i), dut_lane(i), 0);
      check_eq("mid_rst_frame_cnt", int'(frame_cnt), 0);
      check_eq("mid_rst_frame_valid", int'(frame_valid), 0);
      check_eq("mid_rst_sum_valid", int'(sum_valid), 0);
      model_idx = 0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      for (int i = 0; i < 8; i++) send(100 + i, 1'b0);

      // Drain outstanding expectations
      t = 0;
      while ((exp_q.size() != 0 || sum_q.size() != 0) && t < 100) begin
         idle(1);
         t++;
      end
      check_eq("drain_frames", exp_q.size(), 0);
      check_eq("drain_sums", sum_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
